// File: rtl/dmem_resp_if.sv
// Load/store bus between the CPU datapath (master) and the data-memory responder (slave).
// Handshake: the master holds req with we/adr/wdata stable until the slave accepts in IDLE; completion is the one-cycle ack pulse, qualified by err, with rdata valid while ack=1.
interface dmem_resp_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (
        output req, we, adr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, adr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder with WAIT_CYCLES wait states between request acceptance and ack.
// Define DMEM_RESP_ERR_EN to reject misaligned or out-of-range addresses with err=1.
module dmem_resp #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_resp_if.slave bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic                r_reject;
    logic [31:0]         r_mem [DEPTH];
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_busy;
    logic                r_err;

    logic                w_reject;
    logic                w_unused_adr;

`ifdef DMEM_RESP_ERR_EN
    assign w_reject = (bus.adr[1:0] != 2'b00) || (bus.adr[31:ADDR_W+2] != '0);
`else
    assign w_reject = 1'b0;
`endif
    // Byte-offset and upper address bits only matter when rejection is enabled.
    assign w_unused_adr = ^{bus.adr[31:ADDR_W+2], bus.adr[1:0]};

    // The RESP state is the last cycle of the transaction: its closing edge commits
    // the write or loads rdata and raises ack, so ack shows up WAIT_CYCLES+1 edges after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= 32'd0;
            r_reject <= 1'b0;
            r_rdata  <= 32'd0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we     <= bus.we;
                        r_idx    <= bus.adr[ADDR_W+1:2];
                        r_wdata  <= bus.wdata;
                        r_reject <= w_reject;
                        r_busy   <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b1;
                    r_err   <= r_reject;
                    r_state <= S_IDLE;
                    if (r_reject) begin
                        r_rdata <= 32'd0;
                    end else if (r_we) begin
                        r_mem[r_idx] <= r_wdata;
                    end else begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata   = r_rdata;
    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
    assign o_dbg_state = r_state;

endmodule
